// File: rtl/io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_port_ctrl
// Purpose  : Memory-mapped I/O port: debounced inputs with sticky rising-edge
//            flags, registered outputs, masked IRQ, req/ack bus slave.
//            Define IO_PORT_OUT_ATOMIC_EN for OUT_SET/OUT_CLR/OUT_TGL at 4..6.
// Revision : 1.0 - initial release
// ============================================================================
module io_port_ctrl #(
    parameter int DATA_W     = 32,
    parameter int IO_W       = 4,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
`ifdef IO_PORT_OUT_ATOMIC_EN
    input  logic [2:0]        addr,
`else
    input  logic [1:0]        addr,
`endif
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    input  logic [IO_W-1:0]   in,
    output logic [IO_W-1:0]   out,
    output logic              irq
);

`ifdef IO_PORT_OUT_ATOMIC_EN
    localparam int AW = 3;
`else
    localparam int AW = 2;
`endif
    localparam logic [AW-1:0]    C_A_IN     = AW'(0);
    localparam logic [AW-1:0]    C_A_OUT    = AW'(1);
    localparam logic [AW-1:0]    C_A_EDGE   = AW'(2);
    localparam logic [AW-1:0]    C_A_EN     = AW'(3);
`ifdef IO_PORT_OUT_ATOMIC_EN
    localparam logic [AW-1:0]    C_A_SET    = AW'(4);
    localparam logic [AW-1:0]    C_A_CLR    = AW'(5);
    localparam logic [AW-1:0]    C_A_TGL    = AW'(6);
`endif
    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                w_acc;
    logic                w_wr;
    logic [IO_W-1:0]     w_wd;
    logic [IO_W-1:0]     sync1_q, sync2_q;
    logic [IO_W-1:0]     db_q, w_db_d;
    logic [IO_W-1:0]     edge_q, edge_d;
    logic [IO_W-1:0]     irq_en_q, irq_en_d;
    logic [IO_W-1:0]     out_q, out_d;
    logic [IO_W-1:0]     w_clr;
    logic [IO_W-1:0]     w_rsel;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                irq_q;

    assign w_wd = wdata[IO_W-1:0];

    generate
        if (IO_W < DATA_W) begin : g_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^wdata[DATA_W-1:IO_W];
        end
    endgenerate

    // Per-bit debounce: DB follows S only after DEB_CYCLES consecutive mismatches.
    generate
        for (genvar g = 0; g < IO_W; g++) begin : g_deb
            logic [CNT_W-1:0] cnt_q;
            logic             w_diff;
            logic             w_hit;

            assign w_diff    = sync2_q[g] ^ db_q[g];
            assign w_hit     = w_diff && (cnt_q == C_DEB_LAST);
            assign w_db_d[g] = w_hit ? sync2_q[g] : db_q[g];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else if (!w_diff || w_hit) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        w_acc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_RESP;
                    w_acc   = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_wr = w_acc & we;

    always_comb begin
        w_rsel = '0;
        case (addr)
            C_A_IN:   w_rsel = db_q;
            C_A_OUT:  w_rsel = out_q;
            C_A_EDGE: w_rsel = edge_q;
            C_A_EN:   w_rsel = irq_en_q;
            default:  w_rsel = '0;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (w_acc) begin
            rdata_d[IO_W-1:0] = w_rsel;
        end
    end

    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        w_clr    = '0;
        if (w_wr) begin
            case (addr)
                C_A_OUT:  out_d    = w_wd;
                C_A_EDGE: w_clr    = w_wd;
                C_A_EN:   irq_en_d = w_wd;
`ifdef IO_PORT_OUT_ATOMIC_EN
                C_A_SET:  out_d    = out_q | w_wd;
                C_A_CLR:  out_d    = out_q & ~w_wd;
                C_A_TGL:  out_d    = out_q ^ w_wd;
`endif
                default:  ;
            endcase
        end
    end

    // A new rising edge outranks a simultaneous software clear.
    assign edge_d = (edge_q & ~w_clr) | (w_db_d & ~db_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            out_q    <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= in;
            sync2_q  <= sync1_q;
            db_q     <= w_db_d;
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            out_q    <= out_d;
            rdata_q  <= rdata_d;
            irq_q    <= |(edge_q & irq_en_q);
        end
    end

    assign ack   = (state_q == ST_RESP);
    assign rdata = rdata_q;
    assign out   = out_q;
    assign irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_io_port_ctrl
// Purpose  : Directed bench for io_port_ctrl (DEB_CYCLES=4) with a cycle
//            model; IO_PORT_OUT_ATOMIC_EN adds the atomic OUT register tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_ctrl;
    localparam int DEB = 4;
`ifdef IO_PORT_OUT_ATOMIC_EN
    localparam int AW = 3;
`else
    localparam int AW = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata;
    logic          ack;
    logic [3:0]    in, out;
    logic          irq;

    int total = 0;
    int bad   = 0;

    io_port_ctrl #(.DATA_W(32), .IO_W(4), .DEB_CYCLES(DEB), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack),
        .in(in), .out(out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: DB adopts S once S has held a value different from DB for DEB samples.
    logic [3:0]  m_s1, m_s2, m_last, m_db, m_edge, m_en, m_out;
    int          m_run [4];
    logic        m_resp, m_irq;
    logic [31:0] m_rdata;

    function automatic logic [3:0] m_read(input int a);
        case (a)
            0:       return m_db;
            1:       return m_out;
            2:       return m_edge;
            3:       return m_en;
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [3:0]  n_db, n_out, n_en, clr;
        logic [31:0] n_rd;
        logic        n_resp;
        int          a;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_last = 0; m_db = 0; m_edge = 0; m_en = 0;
            m_out = 0; m_resp = 0; m_irq = 0; m_rdata = 0;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
        end else begin
            n_db = m_db;
            for (int b = 0; b < 4; b++) begin
                if (m_s2[b] == m_last[b]) m_run[b] = (m_run[b] < 1000) ? m_run[b] + 1 : 1000;
                else m_run[b] = 1;
                if (m_s2[b] != m_db[b] && m_run[b] >= DEB) n_db[b] = m_s2[b];
            end
            m_last = m_s2;
            n_out = m_out; n_en = m_en; clr = 0; n_resp = 0; n_rd = 0;
            a = int'(addr);
            if (!m_resp && req) begin
                n_resp = 1;
                n_rd   = {28'h0, m_read(a)};
                if (we) begin
                    case (a)
                        1: n_out = wdata[3:0];
                        2: clr   = wdata[3:0];
                        3: n_en  = wdata[3:0];
`ifdef IO_PORT_OUT_ATOMIC_EN
                        4: n_out = m_out | wdata[3:0];
                        5: n_out = m_out & ~wdata[3:0];
                        6: n_out = m_out ^ wdata[3:0];
`endif
                        default: ;
                    endcase
                end
            end
            m_irq   = |(m_edge & m_en);
            m_edge  = (m_edge & ~clr) | (n_db & ~m_db);
            m_db    = n_db;
            m_s2    = m_s1;
            m_s1    = in;
            m_out   = n_out;
            m_en    = n_en;
            m_resp  = n_resp;
            m_rdata = n_rd;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("cyc_ack",   {31'h0, ack}, {31'h0, m_resp});
            chk("cyc_rdata", rdata,        m_rdata);
            chk("cyc_out",   {28'h0, out}, {28'h0, m_out});
            chk("cyc_irq",   {31'h0, irq}, {31'h0, m_irq});
        end
    end

    task automatic bus_wr(input int a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = AW'(a); wdata = d;
        @(negedge clk);
        chk("wr_ack", {31'h0, ack}, 32'h1);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_rd(input int a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = AW'(a);
        @(negedge clk);
        chk("rd_ack", {31'h0, ack}, 32'h1);
        d = rdata;
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          n;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; in = 4'hF;
        repeat (10) @(negedge clk);
        chk("rst_out",   {28'h0, out}, 32'h0);
        chk("rst_irq",   {31'h0, irq}, 32'h0);
        chk("rst_ack",   {31'h0, ack}, 32'h0);
        chk("rst_rdata", rdata,        32'h0);
        rst = 1'b1;
        // reads sampled 1,3,5,7 cycles after release; DB flips 6 cycles after
        for (int i = 0; i < 4; i++) begin
            bus_rd(0, d);
            chk("rel_in", d, (i == 3) ? 32'hF : 32'h0);
        end
        bus_rd(2, d);
        chk("rel_edge", d, 32'hF);
        bus_wr(2, 32'hF);
        in = 4'h0;
        repeat (10) @(negedge clk);
        bus_rd(0, d);
        chk("in_low", d, 32'h0);

        // glitch of 3 cycles must not reach DB
        in = 4'h1;
        repeat (3) @(negedge clk);
        in = 4'h0;
        repeat (10) @(negedge clk);
        bus_rd(0, d);
        chk("glitch_in", d, 32'h0);
        bus_rd(2, d);
        chk("glitch_edge", d, 32'h0);
        in = 4'h1;
        repeat (4) @(negedge clk);
        bus_rd(0, d);
        chk("deb_early", d, 32'h0);
        bus_rd(0, d);
        chk("deb_in", d, 32'h1);
        bus_rd(2, d);
        chk("deb_edge", d, 32'h1);
        bus_wr(2, 32'h1);

        req = 1'b1; we = 1'b1; addr = AW'(1); wdata = 32'hFFFF_FFF5;
        @(negedge clk);
        chk("out_ack", {31'h0, ack}, 32'h1);
        chk("out_val", {28'h0, out}, 32'h5);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("out_ack_once", {31'h0, ack}, 32'h0);
        bus_rd(1, d);
        chk("out_rd", d, 32'h5);

        bus_wr(3, 32'h2);
        in = 4'h3;
        repeat (6) @(negedge clk);
        chk("irq_before", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_set", {31'h0, irq}, 32'h1);
        repeat (13) @(negedge clk);
        in = 4'h1;
        bus_wr(2, 32'h2);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        repeat (10) @(negedge clk);
        bus_rd(2, d);
        chk("edge_clr", d, 32'h0);

        // W1C of EDGE[2] lands on the same edge DB[2] rises
        in = 4'h5;
        repeat (5) @(negedge clk);
        bus_wr(2, 32'h4);
        bus_rd(2, d);
        chk("collide", d, 32'h4);
        bus_wr(2, 32'h4);

        n = 0;
        req = 1'b1; we = 1'b0; addr = AW'(0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) n++;
        end
        req = 1'b0;
        @(negedge clk);
        if (ack) n++;
        chk("held_acks", n, 32'd3);

`ifdef IO_PORT_OUT_ATOMIC_EN
        bus_wr(1, 32'h5);
        bus_wr(6, 32'h3);
        chk("tgl", {28'h0, out}, 32'h6);
        bus_wr(4, 32'h8);
        chk("set", {28'h0, out}, 32'hE);
        bus_wr(5, 32'h4);
        chk("clr", {28'h0, out}, 32'hA);
        bus_wr(7, 32'hF);
        chk("unmapped", {28'h0, out}, 32'hA);
        bus_rd(4, d);
        chk("rd_set", d, 32'h0);
`endif

        // reset lands between request and the accepting edge
        req = 1'b1; we = 1'b1; addr = AW'(1); wdata = 32'hA;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_ack", {31'h0, ack}, 32'h0);
        chk("abort_out", {28'h0, out}, 32'h0);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus_rd(1, d);
        chk("abort_rd", d, 32'h0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Parametrised memory-mapped I/O port controller for the microprogrammed RISC-V datapath. It succeeds the fixed 4-bit in/out pass-through.
- Provides IO_W-bit inputs with synchronisers, debounce and sticky rising-edge flags.
- Provides an IO_W-bit registered output and an interrupt request line.
- The datapath load/store unit accesses it through a one-outstanding-request req/ack bus.

Parameters:
- DATA_W, 32, datapath word width; rdata/wdata width.
- IO_W, 4, number of input pins and of output pins; legal range 1..DATA_W.
- DEB_CYCLES, 16, consecutive stable cycles required before a debounced input bit changes; legal range 1..65535.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  1  bus access request; held until ack.
- we  input  1  1 = write, 0 = read; valid with req.
- addr  input  2  word register index.
- wdata  input  DATA_W  write data; bits [IO_W-1:0] used.
- rdata  output  DATA_W  read data; valid while ack=1, zero-extended.
- ack  output  1  single-cycle access-complete pulse.
- in  input  IO_W  asynchronous external inputs.
- out  output  IO_W  registered output port.
- irq  output  1  level interrupt request.

Behaviour:
- Clock is clk. Reset is rst, asynchronous, active-low.
- Reset (rst=0): all flops clear immediately. ack=0, rdata=0, out=0, irq=0; sync stages, debounced value DB, EDGE, IRQ_EN and all counters = 0. FSM enters IDLE.
- Input path, per bit:
  - Two-flop synchroniser produces S.
  - Counter clears when S==DB; otherwise it increments.
  - When the counter reaches DEB_CYCLES-1 while S!=DB, DB takes S and the counter clears.
  - Latency from a stable pin change to DB change = 2 + DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES cycles never changes DB.
- EDGE[i] sets on the cycle DB[i] goes 0->1 and stays set until cleared by software.
- Register map (addr):
  - 0 IN: DB, read-only; writes ignored.
  - 1 OUT: read/write; the out pins are driven directly from this register.
  - 2 EDGE: reading returns the flags; writing a 1 to a bit clears it (W1C).
  - 3 IRQ_EN: read/write mask.
- irq is registered: irq = |(EDGE & IRQ_EN), updated one cycle after EDGE/IRQ_EN change.
- Bus FSM states: IDLE, RESP.
  - IDLE with req=1: perform the write, or capture read data; go to RESP.
  - RESP: ack=1 and rdata valid for exactly one cycle; return to IDLE.
  - rdata returns to 0 outside RESP.
  - req is ignored while in RESP. A held req re-triggers in IDLE, so maximum throughput is one access per 2 cycles; the master must drop req in the cycle after ack.
- Write timing: the write takes effect on the IDLE->RESP edge, so out changes in the same cycle ack rises.
- Read timing: reads return register values as sampled on the IDLE->RESP edge.
- Simultaneous EDGE set and W1C clear of the same bit: set wins and the bit stays 1.
- Simultaneous DB change and read of IN: the read returns the pre-change value.
- Reset mid-access: the access is aborted, no ack is issued, and an OUT write in flight is lost.

Optional Feature:
- Macro: IO_PORT_OUT_ATOMIC_EN.
- Defined:
  - addr is widened to 3 bits.
  - Index 4 OUT_SET: write ORs wdata into OUT.
  - Index 5 OUT_CLR: write ANDs ~wdata into OUT.
  - Index 6 OUT_TGL: write XORs wdata into OUT.
  - Reads of indices 4-7 return 0; index 7 is unmapped and writes to it are ignored.
  - ack timing is unchanged.
- Not defined:
  - addr is 2 bits, there are only 4 registers, and the above logic is absent.

Test Plan:
- Reset: hold rst=0 with in=4'hF for 10 cycles, then release -> out=0, irq=0, ack=0, and a read of IN returns 0 until 2+DEB_CYCLES cycles after release.
- Debounce (DEB_CYCLES=4): in[0]=1 for 3 cycles, then 0 -> IN reads 0 and EDGE=0. Holding in[0]=1 -> IN reads 32'h1 from cycle 6 onward, and EDGE[0]=1.
- Write/read OUT: req=1, we=1, addr=1, wdata=32'hFFFF_FFF5 -> ack on next cycle only, out=4'h5. A following read of addr=1 returns rdata=32'h0000_0005 with ack.
- IRQ: IRQ_EN=4'h2, pulse in[1] high for 20 cycles -> irq=1 one cycle after EDGE[1] sets. Writing addr=2 with wdata=4'h2 -> EDGE=0 and irq=0 the next cycle.
- Collision: write W1C to EDGE[2] in the same cycle DB[2] rises -> EDGE[2] remains 1.
- Held req: keep req=1 for 6 cycles on a read -> exactly 3 ack pulses, on alternating cycles. With IO_PORT_OUT_ATOMIC_EN, OUT=4'h5 followed by a write of 4'h3 to OUT_TGL (addr=6) -> out=4'h6.
